// File: rtl/neuron.sv
// LIF spiking neuron: weight RAM, input accumulator, selectable leak, threshold/reset.
// Define NEURON_SAT_EN for saturating sums; otherwise sums wrap.
module neuron #(
  parameter int WEIGHT_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        time_step,
  input  logic        load,
  input  logic [9:0]  address,
  input  logic [31:0] value,
  input  logic [2:0]  decay_mode,
  input  logic [1:0]  adder_model,
  input  logic [2:0]  init_mode_adder,
  input  logic        init_mode_acc,
  output logic        spike
);
  localparam int AW = (WEIGHT_DEPTH > 1) ? $clog2(WEIGHT_DEPTH) : 1;

  typedef enum logic [2:0] {
    D_IDLE = 3'd0, D_LIF2 = 3'd1, D_LIF4 = 3'd2, D_LIF8 = 3'd3, D_LIF24 = 3'd4
  } decay_e;

  localparam logic [1:0] M_LIF = 2'd1;
  localparam int P_C  = 2;
  localparam int P_VT = 4;

  logic [31:0] w   [WEIGHT_DEPTH];
  // A, B, C, D, VT, U; only C and VT are consumed by the LIF path
  logic [31:0] prm [6];
  logic [31:0] v, acc;

  logic          in_range, step_en, fire;
  logic [AW-1:0] widx;
  logic [31:0]   wsel, dv, vn;

  function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
`ifdef NEURON_SAT_EN
    if (a[31] == b[31] && s[31] != a[31])
      s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return s;
  endfunction

  always_comb begin
    in_range = (address != '0) && (32'(address) < WEIGHT_DEPTH);
    widx     = address[AW-1:0];
    wsel     = w[widx];
    case (decay_e'(decay_mode))
      D_LIF2:  dv = v - 32'($signed(v) >>> 1);
      D_LIF4:  dv = v - 32'($signed(v) >>> 2);
      D_LIF8:  dv = v - 32'($signed(v) >>> 3);
      D_LIF24: dv = v - 32'($signed(v) >>> 2) - 32'($signed(v) >>> 4);
      default: dv = v;
    endcase
    step_en = time_step && (adder_model == M_LIF) && (decay_mode != D_IDLE) && !init_mode_acc;
    vn      = add32(dv, acc);
    fire    = $signed(vn) >= $signed(prm[P_VT]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v     <= '0;
      acc   <= '0;
      spike <= 1'b0;
      for (int i = 0; i < WEIGHT_DEPTH; i++) w[i] <= '0;
      for (int i = 0; i < 6; i++) prm[i] <= '0;
    end else begin
      spike <= 1'b0;
      if (load && init_mode_acc && in_range) w[widx] <= value;
      if (load && decay_mode == D_IDLE) v <= value;
      if (load && init_mode_adder != 3'd0 && init_mode_adder != 3'd7)
        prm[init_mode_adder - 3'd1] <= value;
      // a step never coincides with a potential load: step requires decay_mode != IDLE
      if (step_en) begin
        acc <= '0;
        if (fire) begin
          spike <= 1'b1;
          v     <= prm[P_C];
        end else begin
          v <= vn;
        end
      end else if (!init_mode_acc && !time_step && in_range) begin
        acc <= add32(acc, wsel);
      end
    end
  end
endmodule

// File: tb/tb_neuron.sv
// Scoreboard bench for neuron: model predicts each time step, compared one cycle later.
module tb_neuron;
  logic        clk = 1'b0;
  logic        rst, time_step, load, init_mode_acc;
  logic [9:0]  address;
  logic [31:0] value;
  logic [2:0]  decay_mode, init_mode_adder;
  logic [1:0]  adder_model;
  logic        spike;

  neuron dut (
    .clk(clk), .rst(rst), .time_step(time_step), .load(load), .address(address),
    .value(value), .decay_mode(decay_mode), .adder_model(adder_model),
    .init_mode_adder(init_mode_adder), .init_mode_acc(init_mode_acc), .spike(spike)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        spk;
    logic [31:0] v;
    logic [31:0] acc;
  } sb_t;

  sb_t sbq[$];
  int  n_cmp = 0, n_bad = 0;

  logic [31:0] mw [16];
  logic [31:0] mv, macc, mc, mvt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef NEURON_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  function automatic logic [31:0] m_decay(input logic [2:0] m, input logic [31:0] x);
    longint a, r;
    a = longint'($signed(x));
    case (m)
      3'd1:    r = a - (a >>> 1);
      3'd2:    r = a - (a >>> 2);
      3'd3:    r = a - (a >>> 3);
      3'd4:    r = a - (a >>> 2) - (a >>> 4);
      default: r = a;
    endcase
    return r[31:0];
  endfunction

  task automatic idle_inputs();
    load = 1'b0; time_step = 1'b0; address = '0; value = '0;
    init_mode_acc = 1'b0; init_mode_adder = 3'd7;
  endtask

  task automatic wr_w(input int a, input logic [31:0] d);
    load = 1'b1; init_mode_acc = 1'b1; address = 10'(a); value = d;
    @(posedge clk); #1;
    if (a > 0 && a < 16) mw[a] = d;
    idle_inputs();
  endtask

  task automatic wr_v(input logic [31:0] d);
    logic [2:0] keep;
    keep = decay_mode;
    load = 1'b1; init_mode_acc = 1'b1; decay_mode = 3'd0; value = d;
    @(posedge clk); #1;
    mv = d;
    idle_inputs();
    decay_mode = keep;
  endtask

  task automatic wr_p(input logic [2:0] sel, input logic [31:0] d);
    load = 1'b1; init_mode_acc = 1'b1; init_mode_adder = sel; value = d;
    @(posedge clk); #1;
    if (sel == 3'd3) mc = d;
    if (sel == 3'd5) mvt = d;
    idle_inputs();
  endtask

  task automatic inject(input int a, input int cycles);
    address = 10'(a);
    repeat (cycles) begin
      @(posedge clk); #1;
      if (a > 0 && a < 16) macc = m_add(macc, mw[a]);
    end
    address = '0;
  endtask

  task automatic step(input int a, input string tag);
    sb_t e, got;
    logic [31:0] d, vn;
    e.tag = tag;
    e.spk = 1'b0;
    if (adder_model == 2'd1 && decay_mode != 3'd0) begin
      d  = m_decay(decay_mode, mv);
      vn = m_add(d, macc);
      macc = '0;
      if ($signed(vn) >= $signed(mvt)) begin
        e.spk = 1'b1; mv = mc;
      end else begin
        mv = vn;
      end
    end
    e.v = mv; e.acc = macc;
    sbq.push_back(e);
    time_step = 1'b1; address = 10'(a);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    got = sbq.pop_front();
    chk({got.tag, "_spike"}, 32'(spike), 32'(got.spk));
    chk({got.tag, "_v"}, dut.v, got.v);
    chk({got.tag, "_acc"}, dut.acc, got.acc);
    @(negedge clk);
    chk({got.tag, "_spike_clr"}, 32'(spike), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mw[i] = '0;
    mv = '0; macc = '0; mc = '0; mvt = '0;

    // reset with junk on every input
    rst = 1'b0; time_step = 1'b1; load = 1'b1; address = 10'd1; value = 32'hDEAD_BEEF;
    decay_mode = 3'd0; adder_model = 2'd1; init_mode_adder = 3'd3; init_mode_acc = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle_inputs();
    decay_mode = 3'd4; adder_model = 2'd1;
    @(negedge clk);
    chk("rst_spike", 32'(spike), 32'd0);
    chk("rst_v", dut.v, 32'd0);
    chk("rst_acc", dut.acc, 32'd0);
    inject(1, 1); inject(2, 1); inject(3, 1);
    @(negedge clk);
    chk("rst_weights", dut.acc, 32'd0);

    wr_w(1, 32'h0000_D125); wr_w(2, 32'h0000_0FFF); wr_w(3, 32'h0000_F501);
    wr_v(32'h0000_BCB5);
    wr_p(3'd3, 32'd1); wr_p(3'd5, 32'h0002_FFFF);

    inject(1, 1); inject(2, 1); inject(3, 1);
    @(negedge clk);
    chk("step1_acc", dut.acc, 32'd120357);
    step(0, "step1");
    chk("step1_v_abs", dut.v, 32'h0002_57E2);

    inject(1, 1); inject(3, 1);
    step(2, "step2");
    chk("step2_v_abs", dut.v, 32'd1);

    inject(2, 3);
    @(negedge clk);
    chk("hold3_acc", dut.acc, 32'h0000_2FFD);
    chk("hold3_model", dut.acc, macc);
    inject(0, 2);
    @(negedge clk);
    chk("addr0_acc", dut.acc, macc);
    wr_w(20, 32'h0000_0055);
    inject(20, 1); inject(4, 1);
    @(negedge clk);
    chk("oob_acc", dut.acc, macc);

    adder_model = 2'd0;
    step(1, "ign_none");
    adder_model = 2'd3;
    step(0, "ign_model3");
    adder_model = 2'd1;
    step(0, "lif24_flush");

    decay_mode = 3'd1;
    wr_v(-32'sd1000);
    inject(2, 1);
    step(0, "lif2_neg");
    decay_mode = 3'd2;
    wr_v(32'd100000);
    step(0, "lif4");
    decay_mode = 3'd3;
    wr_v(32'd80000);
    inject(3, 2);
    step(0, "lif8");
    decay_mode = 3'd6;
    wr_v(32'd150000);
    inject(1, 1);
    step(0, "lif0_m6");

    // saturation corner
    decay_mode = 3'd5;
    wr_w(1, 32'h0000_1000);
    wr_v(32'h7FFF_FF00);
    wr_p(3'd5, 32'h7FFF_FFFF);
    inject(1, 1);
    step(0, "sat");
`ifdef NEURON_SAT_EN
    chk("sat_v_abs", dut.v, 32'd1);
`else
    chk("sat_v_abs", dut.v, 32'h8000_0F00);
`endif

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
